peak_scan_ctrl: RTL
===================

PEAK_SCAN_CTRL -- requirements
Module: peak_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 1024, number of spectrum bins per frame (2..2048).
REQ-002 Parameter MIN_BIN, default 1, first bin scanned; bins below it are excluded (DC rejection), 0 <= MIN_BIN < WIDTH.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame_ready  input  1  one-cycle pulse: a new spectrum frame is complete in magnitude RAM.
REQ-006 scan_en  input  1  level; when low, frame_ready is ignored and no pending request is recorded.
REQ-007 threshold  input  10  hit threshold, sampled in the cycle peak_valid is asserted.
REQ-008 ram_addr  output  11  magnitude RAM read address (bin index).
REQ-009 ram_rd  output  1  read strobe; read data is valid exactly one cycle after ram_rd.
REQ-010 ram_data  input  10  magnitude returned by RAM.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 peak_valid  output  1  one-cycle pulse: peak_freq, peak_amp and hit are updated.
REQ-013 peak_freq  output  13  4 * bin index of the peak, zero-extended.
REQ-014 peak_amp  output  10  magnitude at the peak bin.
REQ-015 hit  output  1  peak_amp >= threshold, updated with peak_valid and held until the next peak_valid.
REQ-016 overrun  output  1  sticky; set when a frame_ready arrives while a request is already pending.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE -> READ on frame_ready && scan_en, or on a pending request; ram_addr = MIN_BIN and ram_rd = 1 in the first READ cycle.
REQ-019 In READ, ram_addr SHALL increment by 1 per cycle with ram_rd = 1; after issuing WIDTH-1 the next state is DRAIN.
REQ-020 In DRAIN, ram_rd = 0; the last returned sample is compared; the next state is DONE.
REQ-021 In DONE, peak_valid = 1 for exactly one cycle and outputs are registered; the next state is IDLE.
REQ-022 Latency: with frame_ready at cycle T and N = WIDTH-MIN_BIN, ram_addr = MIN_BIN at T+1, the last address is issued at T+N, DRAIN is at T+N+1, and peak_valid is at T+N+2.
REQ-023 Running max: the first returned sample (bin MIN_BIN) SHALL unconditionally load the running amp and index; each later sample replaces them only if strictly greater.
REQ-024 Ties SHALL resolve to the lowest bin index.
REQ-025 peak_freq SHALL equal {index, 2'b00} with no truncation for index <= 2047.
REQ-026 ram_addr SHALL hold its last value when ram_rd = 0; it never wraps past WIDTH-1.
REQ-027 frame_ready && scan_en while busy SHALL set a one-deep pending flag; a second one while the flag is set SHALL leave the flag set and set overrun.
REQ-028 The pending flag SHALL be cleared on the IDLE -> READ transition it causes; that scan begins the cycle after DONE.
REQ-029 frame_ready in the DONE cycle SHALL be treated as pending, not lost.
REQ-030 Deasserting scan_en mid-scan SHALL NOT abort the current scan.
REQ-031 peak_freq, peak_amp and hit SHALL hold their values between peak_valid pulses.

Reset
REQ-032 Asserting reset_n low at any time, including mid-scan, SHALL immediately force: state IDLE, ram_addr 0, ram_rd 0, busy 0, peak_valid 0, peak_freq 0, peak_amp 0, hit 0, overrun 0, and clear the pending flag and running max.
REQ-033 The first frame_ready after reset_n deasserts SHALL start a clean scan.

Verification
REQ-034 WIDTH=8, MIN_BIN=1, RAM bins 1..7 = {5,9,3,9,1,2,4}, threshold=8, frame_ready at T -> peak_valid at T+9, peak_freq=8, peak_amp=9, hit=1.
REQ-035 All bins = 0, threshold=0 -> peak_freq=4*MIN_BIN, peak_amp=0, hit=1; with threshold=1 -> hit=0.
REQ-036 Peak in last bin (bin 7 = 1023, others 0) -> peak_freq=28, peak_amp=1023; ram_addr never exceeds 7.
REQ-037 Two frame_ready pulses during one scan -> overrun=1, exactly one extra scan, starting the cycle after the first DONE.
REQ-038 reset_n low during READ at bin 4 -> all outputs 0 immediately, no peak_valid; next frame_ready gives the full T+9 latency.
REQ-039 scan_en=0 with frame_ready pulses -> busy stays 0, no ram_rd, no pending request recorded.

Source files
------------

// File: rtl/peak_scan_ctrl.sv
// Scans bins MIN_BIN..WIDTH-1 of a magnitude RAM per frame and reports the strongest bin.
// Frame requests arriving mid-scan are queued one deep; further ones raise a sticky overrun.
module peak_scan_ctrl #(
  parameter int WIDTH   = 1024,
  parameter int MIN_BIN = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_ready,
  input  logic        scan_en,
  input  logic [9:0]  threshold,
  output logic [10:0] ram_addr,
  output logic        ram_rd,
  input  logic [9:0]  ram_data,
  output logic        busy,
  output logic        peak_valid,
  output logic [12:0] peak_freq,
  output logic [9:0]  peak_amp,
  output logic        hit,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [10:0] FIRST_ADDR = 11'(MIN_BIN);
  localparam logic [10:0] LAST_ADDR  = 11'(WIDTH - 1);

  logic [1:0]  state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        dvld_q;
  logic [10:0] didx_q;
  logic        first_q, first_d;
  logic [9:0]  max_amp_q, max_amp_d;
  logic [10:0] max_idx_q, max_idx_d;
  logic [9:0]  pk_amp_q, pk_amp_d;
  logic [10:0] pk_idx_q, pk_idx_d;
  logic        hit_q, hit_d;

  logic req;
  logic take;
  logic amp_ge;

  assign req    = frame_ready && scan_en;
  assign amp_ge = (pk_amp_q >= threshold);

  // Strictly-greater replacement keeps the lowest bin on ties.
  assign take = dvld_q && (first_q || (ram_data > max_amp_q));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    first_d   = first_q;
    max_amp_d = take ? ram_data : max_amp_q;
    max_idx_d = take ? didx_q : max_idx_q;
    pk_amp_d  = pk_amp_q;
    pk_idx_d  = pk_idx_q;
    hit_d     = hit_q;

    if (dvld_q) begin
      first_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req || pend_q) begin
          state_d = S_READ;
          addr_d  = FIRST_ADDR;
          first_d = 1'b1;
          pend_d  = pend_q && req;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 11'd1;
        end
      end
      S_DRAIN: begin
        state_d  = S_DONE;
        pk_amp_d = max_amp_d;
        pk_idx_d = max_idx_d;
      end
      S_DONE: begin
        state_d = S_IDLE;
        hit_d   = amp_ge;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && req) begin
      pend_d = 1'b1;
      if (pend_q) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      dvld_q    <= 1'b0;
      didx_q    <= '0;
      first_q   <= 1'b0;
      max_amp_q <= '0;
      max_idx_q <= '0;
      pk_amp_q  <= '0;
      pk_idx_q  <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      dvld_q    <= (state_q == S_READ);
      didx_q    <= addr_q;
      first_q   <= first_d;
      max_amp_q <= max_amp_d;
      max_idx_q <= max_idx_d;
      pk_amp_q  <= pk_amp_d;
      pk_idx_q  <= pk_idx_d;
      hit_q     <= hit_d;
    end
  end

  // hit tracks the threshold live during the DONE cycle, then holds.
  assign hit        = (state_q == S_DONE) ? amp_ge : hit_q;
  assign ram_addr   = addr_q;
  assign ram_rd     = (state_q == S_READ);
  assign busy       = (state_q != S_IDLE);
  assign peak_valid = (state_q == S_DONE);
  assign peak_freq  = {pk_idx_q, 2'b00};
  assign peak_amp   = pk_amp_q;
  assign overrun    = ovr_q;

endmodule
